multi_dataflow_mdc_engine_gen: RTL and testbench
================================================

MULTI_DATAFLOW_MDC_ENGINE_GEN -- requirements
Module: multi_dataflow_mdc_engine_gen

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of input stream channels (1..8).
REQ-002 SHALL have parameter N_OUT, default 1, number of output stream channels (1..8).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bits per stream beat.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, entries per channel FIFO (power of two, >=2).
REQ-005 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: test_mode_i  in  1  test mode, no functional effect; clear_i  in  1  synchronous soft clear.
REQ-007 SHALL have ports: start_i  in  1  job start; len_i  in  32  beats per output channel; cfg_id_i  in  8  dataflow configuration ID.
REQ-008 SHALL have ports: in_data_i  in  N_IN*DATA_WIDTH; in_valid_i  in  N_IN; in_ready_o  out  N_IN  (streamer-side input channels).
REQ-009 SHALL have ports: core_in_data_o  out  N_IN*DATA_WIDTH; core_in_valid_o  out  N_IN; core_in_ready_i  in  N_IN  (MDC core inputs).
REQ-010 SHALL have ports: core_out_data_i  in  N_OUT*DATA_WIDTH; core_out_valid_i  in  N_OUT; core_out_ready_o  out  N_OUT; core_id_o  out  8.
REQ-011 SHALL have ports: out_data_o  out  N_OUT*DATA_WIDTH; out_valid_o  out  N_OUT; out_ready_i  in  N_OUT.
REQ-012 SHALL have ports: busy_o  out  1; done_o  out  1  one-cycle pulse; out_cnt_o  out  N_OUT*32  delivered beats per channel.

Function
REQ-013 SHALL implement FSM IDLE -> CFG -> RUN -> DONE -> IDLE.
REQ-014 IDLE: start_i=1 latches len_i and cfg_id_i, goes to CFG; start_i ignored in all other states.
REQ-015 CFG: one cycle; core_id_o driven from latched ID from CFG onward, held until next CFG; next state RUN, or DONE if latched len = 0.
REQ-016 RUN: each input channel i SHALL pass through its own FIFO; in_ready_o[i] = RUN and FIFO not full.
REQ-017 Output channel j: core_out_ready_o[j] = RUN and FIFO not full and accepted[j] < len; beats beyond len are never accepted.
REQ-018 FIFO first-word latency SHALL be 1 cycle: beat pushed at cycle t is presented at t+1; full FIFO blocks push even when popping same cycle; empty FIFO presents valid=0.
REQ-019 out_cnt_o[j] SHALL increment on each out_valid_o[j] and out_ready_i[j] handshake, saturating at 2^32-1.
REQ-020 RUN -> DONE when every out_cnt_o[j] = len and all output FIFOs empty; input FIFOs are flushed on entering DONE.
REQ-021 DONE: done_o=1 for exactly one cycle, then IDLE; out_cnt_o held until next CFG, which zeroes it.
REQ-022 busy_o SHALL be 1 in CFG, RUN, DONE; 0 in IDLE.
REQ-023 clear_i=1 in any state SHALL force IDLE next cycle, flush all FIFOs, zero counters, no done_o pulse; clear_i has priority over start_i.
REQ-024 Valid/ready: data SHALL remain stable while valid=1 and ready=0; valid outputs never depend combinationally on ready inputs.

Reset
REQ-025 On rst_ni=0: state IDLE, all FIFOs empty, counters 0, latched len 0, core_id_o 0, all valid/ready outputs 0, busy_o 0, done_o 0.
REQ-026 Reset mid-RUN SHALL discard all buffered beats with no handshake completing afterwards.

Configuration
REQ-027 Macro MDC_ENGINE_PERF_CNT_EN SHALL add outputs perf_cycles_o (32, RUN cycles) and perf_stall_o (32, RUN cycles with any out_valid_o=1 and matching out_ready_i=0), zeroed in CFG, saturating.
REQ-028 Without MDC_ENGINE_PERF_CNT_EN those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 FSM state enum, ctrl struct (start, len, cfg_id) and flags struct (busy, done, out_cnt) SHALL reside in multi_dataflow_mdc_package.
REQ-030 Channel FIFO SHALL be sub-module mdc_stream_fifo (parameters DATA_WIDTH, FIFO_DEPTH), instantiated N_IN+N_OUT times.

Verification
REQ-031 N_IN=3,N_OUT=1, len=4, core adds inputs, always-ready sinks -> 4 outputs in order, done_o one cycle, out_cnt_o=4.
REQ-032 len=0, start -> IDLE,CFG,DONE,IDLE; done_o at cycle 3; no handshakes on any channel.
REQ-033 out_ready_i held 0 for 20 cycles, FIFO_DEPTH=4 -> output FIFO holds 4, core_out_ready_o=0, no data lost after release.
REQ-034 Core offers 6 beats with len=4 -> only 4 accepted, core_out_ready_o low after 4th.
REQ-035 clear_i asserted in RUN after 2 beats -> IDLE next cycle, FIFOs empty, out_cnt_o=0, no done_o.
REQ-036 rst_ni pulsed low mid-RUN, asynchronously to clk_i -> all outputs at reset values immediately; with MDC_ENGINE_PERF_CNT_EN, 10-cycle sink stall -> perf_stall_o=10.

Source files
------------

// File: rtl/multi_dataflow_mdc_engine_gen_pkg.sv
// Shared types for the MDC engine: FSM states, job control and status flags.
// Counters are 32 bits wide and saturate rather than wrap.
package multi_dataflow_mdc_package;

  localparam int MAX_CH = 8;
  localparam int CNT_W  = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       start;
    cnt_t       len;
    logic [7:0] cfg_id;
  } ctrl_t;

  // Per-channel delivered counts, sized for the widest legal N_OUT.
  typedef struct packed {
    logic                    busy;
    logic                    done;
    cnt_t [MAX_CH-1:0]       out_cnt;
  } flags_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/multi_dataflow_mdc_engine_gen_fifo.sv
// Per-channel stream FIFO, 1-cycle first-word latency.
// Backpressure: in_ready_o = not full (a full FIFO never accepts, even while popping); flush empties it.
module mdc_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  push, pop;

  assign in_ready_o  = (count != (AW+1)'(FIFO_DEPTH));
  assign out_valid_o = (count != '0);
  assign out_data_o  = mem[rd_ptr];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_ready_i & out_valid_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/multi_dataflow_mdc_engine_gen.sv
// MDC engine wrapper: buffers streamer/core channels, counts delivered beats, runs IDLE/CFG/RUN/DONE.
// Optional MDC_ENGINE_PERF_CNT_EN adds RUN-cycle and sink-stall counters.
module multi_dataflow_mdc_engine_gen
  import multi_dataflow_mdc_package::*;
#(
  parameter int N_IN       = 3,
  parameter int N_OUT      = 1,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        test_mode_i,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [31:0]                 len_i,
  input  logic [7:0]                  cfg_id_i,
  input  logic [N_IN*DATA_WIDTH-1:0]  in_data_i,
  input  logic [N_IN-1:0]             in_valid_i,
  output logic [N_IN-1:0]             in_ready_o,
  output logic [N_IN*DATA_WIDTH-1:0]  core_in_data_o,
  output logic [N_IN-1:0]             core_in_valid_o,
  input  logic [N_IN-1:0]             core_in_ready_i,
  input  logic [N_OUT*DATA_WIDTH-1:0] core_out_data_i,
  input  logic [N_OUT-1:0]            core_out_valid_i,
  output logic [N_OUT-1:0]            core_out_ready_o,
  output logic [7:0]                  core_id_o,
  output logic [N_OUT*DATA_WIDTH-1:0] out_data_o,
  output logic [N_OUT-1:0]            out_valid_o,
  input  logic [N_OUT-1:0]            out_ready_i,
`ifdef MDC_ENGINE_PERF_CNT_EN
  output logic [31:0]                 perf_cycles_o,
  output logic [31:0]                 perf_stall_o,
`endif
  output logic                        busy_o,
  output logic                        done_o,
  output logic [N_OUT*32-1:0]         out_cnt_o
);

  ctrl_t            ctrl;
  flags_t           flags;
  state_e           state_q, state_d;
  cnt_t             len_q;
  logic [7:0]       id_q, core_id_q;
  cnt_t             acc_q [N_OUT];
  cnt_t             cnt_q [N_OUT];
  logic             run, flush_in, all_done;
  logic [N_IN-1:0]  ififo_rdy, ififo_vld;
  logic [N_OUT-1:0] ofifo_rdy, ofifo_vld;
  logic             unused_test_mode;

  assign unused_test_mode = test_mode_i;
  assign ctrl     = '{start: start_i, len: len_i, cfg_id: cfg_id_i};
  assign run      = (state_q == ST_RUN);
  // Input FIFOs are emptied on the edge that enters DONE, so leftovers never reach the next job.
  assign flush_in = clear_i | ((state_d == ST_DONE) & (state_q != ST_DONE));

  always_comb begin
    flags      = '0;
    flags.busy = (state_q != ST_IDLE);
    flags.done = (state_q == ST_DONE) & ~clear_i;
    for (int j = 0; j < N_OUT; j++) flags.out_cnt[j] = cnt_q[j];
    all_done = ~|ofifo_vld;
    for (int j = 0; j < MAX_CH; j++) begin
      if ((j < N_OUT) && (flags.out_cnt[j] != len_q)) all_done = 1'b0;
    end
  end

  always_comb begin
    out_cnt_o = '0;
    for (int j = 0; j < N_OUT; j++) out_cnt_o[j*32 +: 32] = flags.out_cnt[j];
  end

  assign busy_o    = flags.busy;
  assign done_o    = flags.done;
  assign core_id_o = (state_q == ST_CFG) ? id_q : core_id_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl.start) state_d = ST_CFG;
      ST_CFG:  state_d = (len_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (all_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      id_q      <= '0;
      core_id_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && ctrl.start && !clear_i) begin
        len_q <= ctrl.len;
        id_q  <= ctrl.cfg_id;
      end
      if (state_q == ST_CFG) core_id_q <= id_q;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    mdc_stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_in),
      .in_data_i  (in_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .in_valid_i (in_valid_i[i] & run),
      .in_ready_o (ififo_rdy[i]),
      .out_data_o (core_in_data_o[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid_o(ififo_vld[i]),
      .out_ready_i(core_in_ready_i[i] & run)
    );
    assign in_ready_o[i]      = run & ififo_rdy[i];
    assign core_in_valid_o[i] = run & ififo_vld[i];
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    mdc_stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (clear_i),
      .in_data_i  (core_out_data_i[j*DATA_WIDTH +: DATA_WIDTH]),
      .in_valid_i (core_out_valid_i[j] & core_out_ready_o[j]),
      .in_ready_o (ofifo_rdy[j]),
      .out_data_o (out_data_o[j*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid_o(ofifo_vld[j]),
      .out_ready_i(out_ready_i[j] & run)
    );
    // Beats past the job length are refused at the core boundary.
    assign core_out_ready_o[j] = run & ofifo_rdy[j] & (acc_q[j] < len_q);
    assign out_valid_o[j]      = run & ofifo_vld[j];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j] <= '0;
        cnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (clear_i || (state_q == ST_CFG)) begin
          acc_q[j] <= '0;
          cnt_q[j] <= '0;
        end else begin
          if (core_out_valid_i[j] && core_out_ready_o[j]) acc_q[j] <= acc_q[j] + cnt_t'(1);
          if (out_valid_o[j] && out_ready_i[j]) cnt_q[j] <= sat_inc(cnt_q[j]);
        end
      end
    end
  end

`ifdef MDC_ENGINE_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (clear_i || (state_q == ST_CFG)) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (run) begin
      perf_cycles_o <= sat_inc(perf_cycles_o);
      if (|(out_valid_o & ~out_ready_i)) perf_stall_o <= sat_inc(perf_stall_o);
    end
  end
`endif

endmodule

// File: tb/tb_multi_dataflow_mdc_engine_gen.sv
// Directed bench for multi_dataflow_mdc_engine_gen (defaults N_IN=3, N_OUT=1, FIFO_DEPTH=4).
// Table-driven adder job plus hand-written len=0, stall, overflow, clear and async-reset sequences.
module tb_multi_dataflow_mdc_engine_gen;

  localparam int N_IN  = 3;
  localparam int N_OUT = 1;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  test_mode_i, clear_i, start_i;
  logic [31:0]           len_i;
  logic [7:0]            cfg_id_i;
  logic [N_IN*DW-1:0]    in_data_i;
  logic [N_IN-1:0]       in_valid_i, in_ready_o;
  logic [N_IN*DW-1:0]    core_in_data_o;
  logic [N_IN-1:0]       core_in_valid_o, core_in_ready_i;
  logic [N_OUT*DW-1:0]   core_out_data_i;
  logic [N_OUT-1:0]      core_out_valid_i, core_out_ready_o;
  logic [7:0]            core_id_o;
  logic [N_OUT*DW-1:0]   out_data_o;
  logic [N_OUT-1:0]      out_valid_o, out_ready_i;
  logic                  busy_o, done_o;
  logic [N_OUT*32-1:0]   out_cnt_o;
`ifdef MDC_ENGINE_PERF_CNT_EN
  logic [31:0]           perf_cycles_o, perf_stall_o;
`endif

  multi_dataflow_mdc_engine_gen #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .start_i(start_i), .len_i(len_i), .cfg_id_i(cfg_id_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .core_in_data_o(core_in_data_o), .core_in_valid_o(core_in_valid_o), .core_in_ready_i(core_in_ready_i),
    .core_out_data_i(core_out_data_i), .core_out_valid_i(core_out_valid_i),
    .core_out_ready_o(core_out_ready_o), .core_id_o(core_id_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
`ifdef MDC_ENGINE_PERF_CNT_EN
    .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .out_cnt_o(out_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int out_hs = 0, done_cnt = 0, core_acc = 0, in_hs = 0;

  logic [DW-1:0]      out_q [$];
  logic [3*DW-1:0]    feed_q [$];
  logic               feed_stop;
  logic               core_auto, man_out_vld;
  logic [DW-1:0]      man_out_dat, core_sum;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;
  vec_t tab [4];

  // Behavioural MDC core: adds the three input channels; or a manually driven producer.
  always_comb begin
    core_sum = core_in_data_o[0 +: DW] + core_in_data_o[DW +: DW] + core_in_data_o[2*DW +: DW];
    if (core_auto) begin
      core_out_valid_i = &core_in_valid_o;
      core_out_data_i  = core_sum;
      core_in_ready_i  = {N_IN{(&core_in_valid_o) & core_out_ready_o[0]}};
    end else begin
      core_out_valid_i = man_out_vld;
      core_out_data_i  = man_out_dat;
      core_in_ready_i  = '0;
    end
  end

  always @(negedge clk_i) begin
    if (out_valid_o[0] && out_ready_i[0]) begin
      out_q.push_back(out_data_o[DW-1:0]);
      out_hs++;
    end
    if (done_o) done_cnt++;
    if (core_out_valid_i[0] && core_out_ready_o[0]) core_acc++;
    if (|(in_valid_i & in_ready_o)) in_hs++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [31:0] len, input logic [7:0] id);
    len_i    = len;
    cfg_id_i = id;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  task automatic push_beats(input int n, input logic [31:0] base);
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      v = base + 32'(k);
      feed_q.push_back({v + 32'h20, v + 32'h10, v});
    end
  endtask

  task automatic feed(input int budget);
    int   c;
    logic acc;
    c = 0;
    while (feed_q.size() > 0 && !feed_stop && c < budget) begin
      in_data_i  = feed_q[0];
      in_valid_i = '1;
      acc = &in_ready_o;
      step();
      c++;
      if (acc) feed_q.delete(0);
    end
    in_valid_i = '0;
    if (!feed_stop) chk("feed_drained", 64'(feed_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int c;
    c = 0;
    while (!done_o && c < budget) begin
      step();
      c++;
    end
    chk(nm, done_o, 1'b1);
  endtask

  initial begin
    int   d0, h0, c0, i0, k;
    logic seen, acc, rdy_checked;

    tab[0] = '{32'd1,         32'd2, 32'd3, 32'd6};
    tab[1] = '{32'd10,        32'd20, 32'd30, 32'd60};
    tab[2] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    tab[3] = '{32'd100,       32'd200, 32'd300, 32'd600};

    rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    len_i = '0; cfg_id_i = '0; in_data_i = '0; in_valid_i = '0;
    out_ready_i = '0; core_auto = 1'b1; man_out_vld = 1'b0; man_out_dat = '0;
    feed_stop = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_core_out_ready", core_out_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_core_in_valid", core_in_valid_o, 0);
    chk("rst_core_id", core_id_o, 0);
    chk("rst_out_cnt", out_cnt_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    step();

    // Table job: adder core, always-ready sink
    out_ready_i = 1'b1;
    out_q.delete();
    for (int i = 0; i < 4; i++) feed_q.push_back({tab[i].c, tab[i].b, tab[i].a});
    d0 = done_cnt;
    start_job(4, 8'h5A);
    chk("cfg_busy", busy_o, 1);
    chk("cfg_core_id", core_id_o, 8'h5A);
    fork
      feed(100);
      wait_done(200, "tab_done");
    join
    step();
    chk("tab_done_pulse", 64'(done_cnt - d0), 1);
    chk("tab_idle", busy_o, 0);
    chk("tab_out_cnt", out_cnt_o, 4);
    chk("tab_core_id_held", core_id_o, 8'h5A);
    chk("tab_n_out", 64'(out_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_q.size()) chk($sformatf("tab_out%0d", i), out_q[i], tab[i].exp);
    end

    // len = 0: IDLE, CFG, DONE, IDLE with nothing moving
    core_auto = 1'b0; man_out_vld = 1'b1; man_out_dat = 32'h55;
    in_valid_i = '1; in_data_i = '0;
    h0 = out_hs; c0 = core_acc; i0 = in_hs;
    start_job(0, 8'h11);
    chk("len0_cfg_busy", busy_o, 1);
    chk("len0_cfg_done", done_o, 0);
    chk("len0_cfg_id", core_id_o, 8'h11);
    step();
    chk("len0_done", done_o, 1);
    chk("len0_done_busy", busy_o, 1);
    step();
    chk("len0_idle_done", done_o, 0);
    chk("len0_idle_busy", busy_o, 0);
    chk("len0_no_in_hs", 64'(in_hs - i0), 0);
    chk("len0_no_core_hs", 64'(core_acc - c0), 0);
    chk("len0_no_out_hs", 64'(out_hs - h0), 0);
    chk("len0_out_cnt", out_cnt_o, 0);
    in_valid_i = '0; man_out_vld = 1'b0;

    // Sink stalled 20 cycles: output FIFO fills, then drains in order
    core_auto = 1'b1; out_ready_i = 1'b0;
    out_q.delete();
    push_beats(8, 32'h100);
    c0 = core_acc;
    start_job(8, 8'h22);
    fork
      feed(200);
      begin
        repeat (20) step();
        chk("stall_fifo_fill", 64'(core_acc - c0), 4);
        chk("stall_core_ready", core_out_ready_o, 0);
        chk("stall_out_valid", out_valid_o, 1);
        chk("stall_head_data", out_data_o, 32'h330);
        chk("stall_no_out", 64'(out_q.size()), 0);
        out_ready_i = 1'b1;
        wait_done(200, "stall_done");
      end
    join
    step();
    chk("stall_n_out", 64'(out_q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < out_q.size()) chk($sformatf("stall_out%0d", i), out_q[i], 32'h330 + 32'(3*i));
    end
    chk("stall_out_cnt", out_cnt_o, 8);

    // Core offers 6 beats on a 4-beat job
    core_auto = 1'b0; out_ready_i = 1'b1;
    out_q.delete();
    c0 = core_acc;
    start_job(4, 8'h33);
    k = 0; seen = 1'b0; rdy_checked = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      man_out_vld = (k < 6);
      man_out_dat = 32'hA0 + 32'(k);
      acc = man_out_vld && core_out_ready_o[0];
      step();
      if (acc) k++;
      if (k == 4 && acc && !rdy_checked) begin
        chk("ovf_ready_low", core_out_ready_o, 0);
        rdy_checked = 1'b1;
      end
      if (done_o) seen = 1'b1;
    end
    man_out_vld = 1'b0;
    chk("ovf_done", seen, 1);
    chk("ovf_accepted", 64'(k), 4);
    chk("ovf_core_hs", 64'(core_acc - c0), 4);
    step();
    chk("ovf_n_out", 64'(out_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_q.size()) chk($sformatf("ovf_out%0d", i), out_q[i], 32'hA0 + 32'(i));
    end

    // Soft clear after two delivered beats
    core_auto = 1'b1; out_ready_i = 1'b1;
    out_q.delete();
    push_beats(6, 32'h200);
    d0 = done_cnt;
    start_job(8, 8'h44);
    fork
      feed(200);
      begin
        k = 0;
        while (out_q.size() < 2 && k < 100) begin
          step();
          k++;
        end
        chk("clr_two_beats", 64'(out_q.size()), 2);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        feed_stop = 1'b1;
        chk("clr_busy", busy_o, 0);
        chk("clr_out_cnt", out_cnt_o, 0);
        chk("clr_out_valid", out_valid_o, 0);
        chk("clr_core_in_valid", core_in_valid_o, 0);
        chk("clr_in_ready", in_ready_o, 0);
      end
    join
    step();
    chk("clr_no_done", 64'(done_cnt - d0), 0);
    if (out_q.size() >= 2) begin
      chk("clr_out0", out_q[0], 32'h630);
      chk("clr_out1", out_q[1], 32'h633);
    end
    feed_stop = 1'b0;
    feed_q.delete();
    out_q.delete();
    push_beats(1, 32'h300);
    start_job(1, 8'h55);
    fork
      feed(100);
      wait_done(100, "clr_next_done");
    join
    step();
    chk("clr_next_n_out", 64'(out_q.size()), 1);
    if (out_q.size() >= 1) chk("clr_next_out", out_q[0], 32'h930);

    // Asynchronous reset mid-RUN
    out_ready_i = 1'b0;
    push_beats(4, 32'h400);
    start_job(8, 8'h66);
    fork
      feed(200);
      begin
        repeat (6) step();
        chk("arst_pre_valid", out_valid_o, 1);
        #3 rst_ni = 1'b0;
        #1;
        feed_stop = 1'b1;
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_in_ready", in_ready_o, 0);
        chk("arst_core_in_valid", core_in_valid_o, 0);
        chk("arst_core_out_ready", core_out_ready_o, 0);
        chk("arst_out_valid", out_valid_o, 0);
        chk("arst_core_id", core_id_o, 0);
        chk("arst_out_cnt", out_cnt_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        out_ready_i = 1'b1;
        h0 = out_hs;
        repeat (5) step();
        chk("arst_no_out_hs", 64'(out_hs - h0), 0);
        chk("arst_post_valid", out_valid_o, 0);
        chk("arst_post_busy", busy_o, 0);
      end
    join
    feed_stop = 1'b0;
    feed_q.delete();

`ifdef MDC_ENGINE_PERF_CNT_EN
    // Ten-cycle sink stall with a beat waiting
    out_ready_i = 1'b0;
    push_beats(4, 32'h0);
    start_job(4, 8'h77);
    fork
      feed(200);
      begin
        k = 0;
        while (!out_valid_o[0] && k < 50) begin
          step();
          k++;
        end
        chk("perf_valid_seen", out_valid_o, 1);
        repeat (10) step();
        out_ready_i = 1'b1;
        wait_done(200, "perf_done");
      end
    join
    chk("perf_stall", perf_stall_o, 10);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
